gshare_bht: RTL and testbench

Parametrised successor to the frontend 2-bit bimodal branch history table. It adds configurable counter width and a global history register (GHR) with speculative shift and mispredict restore, and XORs the GHR into the row index (gshare). A sequential clear engine replaces the single-cycle flush, so the table needs no per-entry reset. It sits in the frontend next to the BTB: the fetch PC comes in, per-slot direction predictions go out, and resolved branches arrive from execute.

---
 rtl/gshare_bht.sv | 115 +++++++++++
 tb/tb_gshare_bht.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gshare_bht.sv
// gshare_bht: gshare branch history table with per-slot saturating counters, a global history register and a sequential clear sweep.
// Ports: clk_i/rst_ni clock and async active-low reset; flush_bp_i restarts the clear sweep;
//   debug_mode_i blocks table writes; vpc_i fetch PC; spec_valid_i/spec_taken_i speculative GHR shift;
//   update_* resolved branch (pc, direction, GHR snapshot, mispredict restore);
//   pred_valid_o/pred_taken_o per-slot prediction; pred_ghr_o current GHR; ready_o table usable.
// Define BHT_GSHARE_EN to enable the GHR; without it the table is indexed by PC only (bimodal).
module gshare_bht #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned GHR_BITS        = 8,
  parameter int unsigned OFFSET          = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       spec_valid_i,
  input  logic                       spec_taken_i,
  input  logic                       update_valid_i,
  input  logic [VLEN-1:0]            update_pc_i,
  input  logic                       update_taken_i,
  input  logic [GHR_BITS-1:0]        update_ghr_i,
  input  logic                       update_mispredict_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [GHR_BITS-1:0]        pred_ghr_o,
  output logic                       ready_o
);
  localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
  localparam int unsigned IPF_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned SLOT_W   = IPF_BITS > 0 ? IPF_BITS : 1;
  localparam int unsigned LO       = IPF_BITS + OFFSET;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e                state;
  logic [ROW_BITS-1:0]   ptr;
  logic [GHR_BITS-1:0]   ghr_q;
  logic [GHR_BITS-1:0]   wr_ghr;
  logic [ROW_BITS-1:0]   rd_row;
  logic [ROW_BITS-1:0]   wr_row;
  logic [SLOT_W-1:0]     wr_slot;
  logic [CTR_BITS-1:0]   ctr_cur;
  logic [CTR_BITS-1:0]   ctr_nxt;
  logic                  valid_q [NR_ROWS][INSTR_PER_FETCH];
  logic [CTR_BITS-1:0]   ctr_q   [NR_ROWS][INSTR_PER_FETCH];
  logic                  unused_pc;

`ifdef BHT_GSHARE_EN
  // A mispredict restore rebuilds history from the snapshot and wins over a same-cycle speculative shift.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ghr_q <= '0;
    else if (update_mispredict_i && update_valid_i) ghr_q <= {update_ghr_i[GHR_BITS-2:0], update_taken_i};
    else if (spec_valid_i) ghr_q <= {ghr_q[GHR_BITS-2:0], spec_taken_i};
  assign wr_ghr = update_ghr_i;
`else
  logic unused_gshare;
  assign ghr_q         = '0;
  assign wr_ghr        = '0;
  assign unused_gshare = ^{spec_valid_i, spec_taken_i, update_ghr_i, update_mispredict_i};
`endif

  assign unused_pc  = ^{vpc_i, update_pc_i};
  assign rd_row     = vpc_i[ROW_BITS+LO-1:LO] ^ ROW_BITS'(ghr_q);
  assign wr_row     = update_pc_i[ROW_BITS+LO-1:LO] ^ ROW_BITS'(wr_ghr);
  assign ready_o    = state == IDLE;
  assign pred_ghr_o = ghr_q;

  generate
    if (INSTR_PER_FETCH == 1) begin : g_one
      assign wr_slot = '0;
    end else begin : g_multi
      assign wr_slot = update_pc_i[LO-1:OFFSET];
    end
  endgenerate

  assign ctr_cur = ctr_q[wr_row][wr_slot];
  assign ctr_nxt = update_taken_i ? (ctr_cur == CTR_MAX ? ctr_cur : ctr_cur + 1'b1)
                                  : (ctr_cur == '0 ? ctr_cur : ctr_cur - 1'b1);

  for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_pred
    assign pred_valid_o[g] = ready_o & valid_q[rd_row][g];
    assign pred_taken_o[g] = ready_o & ctr_q[rd_row][g][CTR_BITS-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (flush_bp_i) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      ptr   <= ptr == ROW_BITS'(NR_ROWS - 1) ? '0 : ptr + 1'b1;
      state <= ptr == ROW_BITS'(NR_ROWS - 1) ? IDLE : CLEAR;
    end

  // The array has no reset: the clear sweep initialises every row instead.
  always_ff @(posedge clk_i)
    if (state == CLEAR) begin
      for (int i = 0; i < INSTR_PER_FETCH; i++) begin
        valid_q[ptr][i] <= 1'b0;
        ctr_q[ptr][i]   <= CTR_INIT;
      end
    end else if (update_valid_i && !debug_mode_i) begin
      valid_q[wr_row][wr_slot] <= 1'b1;
      ctr_q[wr_row][wr_slot]   <= ctr_nxt;
    end
endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: directed table-driven bench for gshare_bht (16 entries, 2 slots, 2-bit counters, 3-bit history).
module tb_gshare_bht;
  localparam int VLEN = 64;
`ifdef BHT_GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            dbg = 1'b0;
  logic [VLEN-1:0] vpc = '0;
  logic            spec_valid = 1'b0;
  logic            spec_taken = 1'b0;
  logic            upd_valid = 1'b0;
  logic [VLEN-1:0] upd_pc = '0;
  logic            upd_taken = 1'b0;
  logic [2:0]      upd_ghr = '0;
  logic            upd_mis = 1'b0;
  logic [1:0]      pred_valid;
  logic [1:0]      pred_taken;
  logic [2:0]      pred_ghr;
  logic            ready;

  int n_chk = 0;
  int n_fail = 0;

  gshare_bht #(
    .VLEN(VLEN), .INSTR_PER_FETCH(2), .NR_ENTRIES(16), .CTR_BITS(2), .GHR_BITS(3), .OFFSET(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_bp_i(flush), .debug_mode_i(dbg), .vpc_i(vpc),
    .spec_valid_i(spec_valid), .spec_taken_i(spec_taken), .update_valid_i(upd_valid),
    .update_pc_i(upd_pc), .update_taken_i(upd_taken), .update_ghr_i(upd_ghr),
    .update_mispredict_i(upd_mis), .pred_valid_o(pred_valid), .pred_taken_o(pred_taken),
    .pred_ghr_o(pred_ghr), .ready_o(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic        dbg;
    logic [63:0] vpc;
    logic [1:0]  ev;
    logic [1:0]  et;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    upd_valid = 1'b0; upd_mis = 1'b0; spec_valid = 1'b0; spec_taken = 1'b0;
    dbg = 1'b0; flush = 1'b0; upd_ghr = '0; upd_taken = 1'b0;
  endtask

  task automatic read(input string name, input logic [63:0] pc, input logic [1:0] ev, input logic [1:0] et);
    vpc = pc;
    #1;
    check({name, "_valid"}, 64'(pred_valid), 64'(ev));
    check({name, "_taken"}, 64'(pred_taken), 64'(et));
  endtask

  task automatic sweep(input string name);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_busy%0d", name, k), 64'(ready), 64'(0));
      tick();
    end
    check({name, "_ready"}, 64'(ready), 64'(1));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 64'h4,  1'b1, 1'b0, 64'h4,  2'b01, 2'b11};
    vecs[1]  = '{1'b1, 64'h4,  1'b1, 1'b0, 64'h4,  2'b01, 2'b11};
    vecs[2]  = '{1'b1, 64'h4,  1'b0, 1'b0, 64'h4,  2'b01, 2'b11};
    vecs[3]  = '{1'b1, 64'h4,  1'b0, 1'b0, 64'h4,  2'b01, 2'b10};
    vecs[4]  = '{1'b1, 64'h4,  1'b0, 1'b0, 64'h4,  2'b01, 2'b10};
    vecs[5]  = '{1'b1, 64'h4,  1'b0, 1'b0, 64'h4,  2'b01, 2'b10};
    vecs[6]  = '{1'b1, 64'h4,  1'b1, 1'b0, 64'h4,  2'b01, 2'b10};
    vecs[7]  = '{1'b1, 64'h4,  1'b1, 1'b0, 64'h4,  2'b01, 2'b11};
    vecs[8]  = '{1'b1, 64'h6,  1'b0, 1'b0, 64'h4,  2'b11, 2'b01};
    vecs[9]  = '{1'b1, 64'h6,  1'b1, 1'b1, 64'h4,  2'b11, 2'b01};
    vecs[10] = '{1'b1, 64'h1E, 1'b1, 1'b0, 64'h1C, 2'b10, 2'b11};
    vecs[11] = '{1'b0, 64'h0,  1'b0, 1'b0, 64'h24, 2'b11, 2'b01};
    vecs[12] = '{1'b0, 64'h0,  1'b0, 1'b0, 64'h0,  2'b00, 2'b11};

    tick();
    tick();
    rst_n = 1'b1;
    check("rst_ghr", 64'(pred_ghr), 64'(0));
    check("rst_valid", 64'(pred_valid), 64'(0));
    check("rst_taken", 64'(pred_taken), 64'(0));
    sweep("init");

    for (int i = 0; i < 13; i++) begin
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut; dbg = vecs[i].dbg;
      tick();
      clear_in();
      read($sformatf("vec%0d", i), vecs[i].vpc, vecs[i].ev, vecs[i].et);
    end

    upd_valid = 1'b1; upd_pc = 64'h1C; upd_taken = 1'b0;
    read("same_cycle_old", 64'h1C, 2'b10, 2'b11);
    tick();
    clear_in();
    read("same_cycle_new", 64'h1C, 2'b11, 2'b10);

    spec_valid = 1'b1; spec_taken = 1'b1;
    #1;
    check("ghr_pre", 64'(pred_ghr), 64'(0));
    tick();
    check("ghr_s1", 64'(pred_ghr), GS ? 64'h1 : 64'h0);
    tick();
    check("ghr_s2", 64'(pred_ghr), GS ? 64'h3 : 64'h0);
    tick();
    check("ghr_s3", 64'(pred_ghr), GS ? 64'h7 : 64'h0);

    upd_valid = 1'b1; upd_mis = 1'b1; upd_ghr = 3'b010; upd_taken = 1'b0; upd_pc = 64'h10;
    tick();
    clear_in();
    check("ghr_restore", 64'(pred_ghr), GS ? 64'h4 : 64'h0);
    read("restore_row", GS ? 64'h8 : 64'h10, 2'b01, 2'b10);

    upd_valid = 1'b1; upd_pc = 64'h0; upd_ghr = 3'b000; upd_taken = 1'b1;
    spec_valid = 1'b1; spec_taken = 1'b1;
    tick();
    clear_in();
    check("ghr_alias", 64'(pred_ghr), GS ? 64'h1 : 64'h0);
    read("alias", 64'h4, GS ? 2'b01 : 2'b11, GS ? 2'b11 : 2'b01);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(ready), 64'(0));
    tick();
    tick();
    read("sweep_mask", 64'h4, 2'b00, 2'b00);
    tick();
    flush = 1'b1; upd_valid = 1'b1; upd_pc = 64'h1C; upd_taken = 1'b0; upd_ghr = GS ? 3'b001 : 3'b000;
    tick();
    clear_in();
    sweep("reflush");
    read("dropped_upd", GS ? 64'h18 : 64'h1C, 2'b00, 2'b11);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(ready), 64'(0));
    check("midrst_ghr", 64'(pred_ghr), 64'(0));
    tick();
    rst_n = 1'b1;
    sweep("midrst");
    check("midrst_ghr_after", 64'(pred_ghr), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
